// File: rtl/mem_image_loader_pkg.sv
// mem_image_loader_pkg: shared types and header layout for the boot-time image loader
// Contents: loader_state_t FSM encoding, segment-header bit positions, pair stride.
package mem_image_loader_pkg;

    typedef enum logic [2:0] {HDR, LO, HI, FLUSH, RUN} loader_state_t;

    localparam int HDR_TARGET_BIT = 31;
    localparam int HDR_LAST_BIT   = 30;
    localparam int HDR_BASE_LSB   = 16;
    localparam int HDR_BASE_W     = 9;
    localparam int HDR_COUNT_LSB  = 0;
    localparam int HDR_COUNT_W    = 9;
    localparam int PAIR_STRIDE    = 8;

endpackage

// File: rtl/mem_image_loader.sv
// mem_image_loader: packs a framed 32-bit word stream into 64-bit pairs and drives the core's debug memory write ports
// Ports: clk, reset (sync, active-low); s_valid/s_ready/s_data stream input; reload restarts from RUN;
//        enable_debug holds the core in debug; DebugAddress/DebugData1/DebugData2 data-memory port;
//        debug_inst_addr/debug_inst_data1/debug_inst_data2 instruction-memory port; load_done high in RUN.
module mem_image_loader
    import mem_image_loader_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int DM_ADDRESS = 9
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_W-1:0]     s_data,
    input  logic                  reload,
    output logic                  enable_debug,
    output logic [DM_ADDRESS-1:0] DebugAddress,
    output logic [DATA_W-1:0]     DebugData1,
    output logic [DATA_W-1:0]     DebugData2,
    output logic [DM_ADDRESS-1:0] debug_inst_addr,
    output logic [DATA_W-1:0]     debug_inst_data1,
    output logic [DATA_W-1:0]     debug_inst_data2,
    output logic                  load_done
);

    loader_state_t state, next_state;
    logic                   tgt, last;
    logic [DM_ADDRESS-1:0]  base, pair_addr;
    logic [HDR_COUNT_W-1:0] count, idx, idx_nxt, hdr_count;
    logic [DATA_W-1:0]      lo_word;
    logic                   accept;

    // Gated by reset so nothing is accepted in the cycle reset is asserted.
    assign s_ready   = reset && (state == HDR || state == LO || state == HI);
    assign accept    = s_valid && s_ready;
    assign idx_nxt   = idx + 1'b1;
    assign hdr_count = s_data[HDR_COUNT_LSB +: HDR_COUNT_W];
    // Pair k lands at base + 8*k; wrap-around modulo the address width is intended.
    assign pair_addr = base + DM_ADDRESS'({idx, 3'b000});

    always_comb begin
        next_state = state;
        case (state)
            HDR:     if (accept) next_state = (hdr_count == '0) ? (s_data[HDR_LAST_BIT] ? FLUSH : HDR) : LO;
            LO:      if (accept) next_state = HI;
            HI:      if (accept) next_state = (idx_nxt == count) ? (last ? FLUSH : HDR) : LO;
            FLUSH:   next_state = RUN;
            RUN:     if (reload) next_state = HDR;
            default: next_state = HDR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state            <= HDR;
            enable_debug     <= 1'b1;
            load_done        <= 1'b0;
            tgt              <= 1'b0;
            last             <= 1'b0;
            base             <= '0;
            count            <= '0;
            idx              <= '0;
            lo_word          <= '0;
            DebugAddress     <= '0;
            DebugData1       <= '0;
            DebugData2       <= '0;
            debug_inst_addr  <= '0;
            debug_inst_data1 <= '0;
            debug_inst_data2 <= '0;
        end else begin
            state        <= next_state;
            // Registered from the next state so the core is released exactly on entry to RUN.
            enable_debug <= (next_state != RUN);
            load_done    <= (next_state == RUN);
            if (accept && state == HDR) begin
                tgt   <= s_data[HDR_TARGET_BIT];
                last  <= s_data[HDR_LAST_BIT];
                base  <= DM_ADDRESS'(s_data[HDR_BASE_LSB +: HDR_BASE_W]);
                count <= hdr_count;
                idx   <= '0;
            end
            if (accept && state == LO)
                lo_word <= s_data;
            if (accept && state == HI) begin
                idx <= idx_nxt;
                if (tgt) begin
                    DebugAddress <= pair_addr;
                    DebugData1   <= lo_word;
                    DebugData2   <= s_data;
                end else begin
                    debug_inst_addr  <= pair_addr;
                    debug_inst_data1 <= lo_word;
                    debug_inst_data2 <= s_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_image_loader.sv
// tb_mem_image_loader: directed scoreboard bench for mem_image_loader
module tb_mem_image_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        s_valid = 1'b0;
    logic        reload = 1'b0;
    logic [31:0] s_data = '0;
    logic        s_ready, enable_debug, load_done;
    logic [8:0]  DebugAddress, debug_inst_addr;
    logic [31:0] DebugData1, DebugData2, debug_inst_data1, debug_inst_data2;

    mem_image_loader dut (
        .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .reload(reload), .enable_debug(enable_debug),
        .DebugAddress(DebugAddress), .DebugData1(DebugData1), .DebugData2(DebugData2),
        .debug_inst_addr(debug_inst_addr), .debug_inst_data1(debug_inst_data1),
        .debug_inst_data2(debug_inst_data2), .load_done(load_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          tgt;
        logic [8:0]  a;
        logic [31:0] d1;
        logic [31:0] d2;
    } wr_t;

    wr_t         q[$];
    logic [31:0] words[$];
    int          total = 0;
    int          bad = 0;
    bit          pend = 0;
    logic [8:0]  mi_a = '0, md_a = '0;
    logic [31:0] mi_1 = '0, mi_2 = '0, md_1 = '0, md_2 = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s got=%h want=%h", tag, obs, exp);
        end
    endtask

    // One clock; apply the scoreboard entry for a pair written on this edge, then compare all ports.
    task automatic tick();
        wr_t w;
        @(posedge clk);
        #1;
        if (!reset) begin
            pend = 0;
            mi_a = '0; mi_1 = '0; mi_2 = '0;
            md_a = '0; md_1 = '0; md_2 = '0;
        end else if (pend) begin
            pend = 0;
            if (q.size() == 0) chk("sb_underflow", 1, 0);
            else begin
                w = q.pop_front();
                if (w.tgt) begin md_a = w.a; md_1 = w.d1; md_2 = w.d2; end
                else begin mi_a = w.a; mi_1 = w.d1; mi_2 = w.d2; end
            end
        end
        chk("inst_addr", 32'(debug_inst_addr), 32'(mi_a));
        chk("inst_d1", debug_inst_data1, mi_1);
        chk("inst_d2", debug_inst_data2, mi_2);
        chk("dm_addr", 32'(DebugAddress), 32'(md_a));
        chk("dm_d1", DebugData1, md_1);
        chk("dm_d2", DebugData2, md_2);
    endtask

    task automatic send(input logic [31:0] w, input bit hi, input int gap);
        int n = 0;
        s_valid = 1'b0;
        repeat (gap) tick();
        s_valid = 1'b1;
        s_data  = w;
        while (!s_ready && n < 20) begin tick(); n++; end
        chk("ready_timeout", 32'(n >= 20), 0);
        pend = hi;
        tick();
        s_valid = 1'b0;
    endtask

    task automatic seg(input logic [31:0] hdr, input bit gaps, input int stall);
        wr_t         w;
        logic [8:0]  base;
        int          n;
        base = hdr[24:16];
        n    = int'(hdr[8:0]);
        send(hdr, 0, gaps ? int'($urandom_range(0, 2)) : 0);
        for (int k = 0; k < n; k++) begin
            send(words[2*k], 0, gaps ? int'($urandom_range(0, 2)) : 0);
            w.tgt = hdr[31];
            w.a   = base + 9'(8 * k);
            w.d1  = words[2*k];
            w.d2  = words[2*k+1];
            q.push_back(w);
            send(words[2*k+1], 1, (k == 0 && stall > 0) ? stall : (gaps ? int'($urandom_range(0, 2)) : 0));
        end
    endtask

    // Called right after the edge that accepted the final word (or last-segment empty header).
    task automatic check_release(input string tag);
        chk({tag, "_flush_en"}, 32'(enable_debug), 1);
        chk({tag, "_flush_rdy"}, 32'(s_ready), 0);
        chk({tag, "_flush_done"}, 32'(load_done), 0);
        tick();
        chk({tag, "_run_en"}, 32'(enable_debug), 0);
        chk({tag, "_run_done"}, 32'(load_done), 1);
        chk({tag, "_run_rdy"}, 32'(s_ready), 0);
        tick();
        chk({tag, "_run_hold"}, 32'(load_done), 1);
    endtask

    task automatic do_reload();
        reload = 1'b1;
        tick();
        reload = 1'b0;
        chk("reload_en", 32'(enable_debug), 1);
        chk("reload_done", 32'(load_done), 0);
        chk("reload_rdy", 32'(s_ready), 1);
    endtask

    initial begin
        reset = 1'b0;
        tick();
        tick();
        chk("rst_en", 32'(enable_debug), 1);
        chk("rst_done", 32'(load_done), 0);
        chk("rst_rdy", 32'(s_ready), 0);
        reset = 1'b1;
        #1;
        chk("rel_rdy", 32'(s_ready), 1);

        words = '{32'h11, 32'h22, 32'h33, 32'h44};
        seg(32'h4000_0002, 0, 0);
        check_release("single");

        do_reload();
        reload = 1'b1;
        tick();
        reload = 1'b0;
        chk("hdr_reload_en", 32'(enable_debug), 1);
        chk("hdr_reload_rdy", 32'(s_ready), 1);
        words = '{};
        seg(32'hC000_0000, 0, 0);
        check_release("empty");

        do_reload();
        words = '{32'hA, 32'hB};
        seg(32'h0000_0001, 0, 0);
        chk("between_en", 32'(enable_debug), 1);
        words = '{32'hC, 32'hD};
        seg(32'hC100_0001, 0, 0);
        check_release("two");

        do_reload();
        words = '{32'h1, 32'h2, 32'h3, 32'h4};
        seg(32'hC1F8_0002, 0, 0);
        check_release("wrap");

        do_reload();
        words = '{32'h11, 32'h22, 32'h33, 32'h44};
        seg(32'h0000_0002, 1, 3);
        words = '{};
        seg(32'h0000_0000, 1, 0);
        words = '{32'hC, 32'hD, 32'hE, 32'hF};
        seg(32'hC100_0002, 1, 0);
        check_release("gaps");

        do_reload();
        send(32'h4000_0001, 0, 0);
        send(32'h55, 0, 0);
        reset = 1'b0;
        #1;
        chk("mid_rst_rdy", 32'(s_ready), 0);
        tick();
        chk("mid_rst_en", 32'(enable_debug), 1);
        chk("mid_rst_done", 32'(load_done), 0);
        reset = 1'b1;
        #1;
        chk("mid_rel_rdy", 32'(s_ready), 1);
        words = '{32'h66, 32'h77};
        seg(32'h4000_0001, 0, 0);
        check_release("fresh");

        chk("sb_left", 32'(q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
